// File: rtl/wb_stage.sv
// Write-back stage: a one-entry buffer between MEM/WB and the register-file
// write port. It selects the result from NSRC packed sources, drives a
// registered write port and a forwarding copy of it, and counts retired entries.
// Optional feature: define WB_LOAD_EXT_EN to extract and sign- or zero-extend
// memory-source results (LB/LH/LBU/LHU) using in_funct3 and in_boff.
// Without the macro the memory source passes through unmodified.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NSRC*XLEN-1:0] in_src,
  input  logic [SELW-1:0]      in_sel,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwrite,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_boff,
  input  logic                 flush,
  input  logic                 rf_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [31:0]          retired
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [4:0]        waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [31:0]       retired_q;

  logic              full;
  logic              complete;
  logic              accept;
  logic [XLEN-1:0]   sel_data;
  logic [XLEN-1:0]   wb_result;
  logic [XLEN-1:0]   src_arr [NSRC];

  // Unpack the flat source bus into one word per source.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = in_src[gi*XLEN +: XLEN];
    end
  endgenerate

  // Source mux; an index with no matching source leaves the result at zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) sel_data = src_arr[k];
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // Pick the addressed byte/halfword of the memory word and extend it by load type.
  always_comb begin
    ld_byte = '0;
    case (in_boff)
      2'd0:    ld_byte = src_arr[1][7:0];
      2'd1:    ld_byte = src_arr[1][15:8];
      2'd2:    ld_byte = src_arr[1][23:16];
      default: ld_byte = src_arr[1][31:24];
    endcase
    ld_half = in_boff[1] ? src_arr[1][31:16] : src_arr[1][15:0];
    case (in_funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = src_arr[1];
    endcase
  end

  assign wb_result = (in_sel == SELW'(1)) ? ld_data : sel_data;
`else
  // Load type and byte offset have no effect when extension is compiled out.
  logic unused_load_fields;
  assign unused_load_fields = ^{in_funct3, in_boff};
  assign wb_result = sel_data;
`endif

  // Handshake terms: the held entry completes once its write (if any) is taken.
  assign full     = (state_q == S_FULL);
  assign complete = full && (!we_q || rf_ready);
  assign accept   = in_valid && in_ready && !flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: flush wins, then a new entry, then completion of the held one.
  always_comb begin
    state_d = state_q;
    if (flush)         state_d = S_EMPTY;
    else if (accept)   state_d = S_FULL;
    else if (complete) state_d = S_EMPTY;
  end

  // Outputs decoded from state: write only while holding a real write.
  always_comb begin
    in_ready  = !full || complete;
    rf_we     = full && we_q;
    fwd_valid = full && we_q;
  end

  // Capture the accepted entry; otherwise hold so a stalled write stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= in_regwrite && (in_rd != 5'd0);
      waddr_q <= in_rd;
      wdata_q <= wb_result;
    end
  end

  // Retirement counter; a flushed entry is not counted. Wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 retired_q <= '0;
    else if (complete && !flush) retired_q <= retired_q + 32'd1;
  end

  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign fwd_rd   = waddr_q;
  assign fwd_data = wdata_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a monitor
// pops them on every accepted register-file write.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_regwrite, flush, rf_ready;
  logic [127:0] in_src;
  logic [1:0]   in_sel, in_boff;
  logic [4:0]   in_rd, rf_waddr, fwd_rd;
  logic [2:0]   in_funct3;
  logic         rf_we, fwd_valid;
  logic [31:0]  rf_wdata, fwd_data, retired;

  // Second instance with three sources to reach an out-of-range select.
  logic         in_valid3, in_ready3, rf_we3, fwd_valid3;
  logic [95:0]  in_src3;
  logic [1:0]   in_sel3;
  logic [4:0]   rf_waddr3, fwd_rd3;
  logic [31:0]  rf_wdata3, fwd_data3, retired3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sel(in_sel), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_funct3(in_funct3), .in_boff(in_boff), .flush(flush), .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired(retired)
  );

  wb_stage #(.NSRC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_src(in_src3), .in_sel(in_sel3), .in_rd(5'd4), .in_regwrite(1'b1),
    .in_funct3(3'b010), .in_boff(2'd0), .flush(1'b0), .rf_ready(1'b1),
    .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3),
    .fwd_valid(fwd_valid3), .fwd_rd(fwd_rd3), .fwd_data(fwd_data3), .retired(retired3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endtask

  // Present one entry for a single edge; push its expected write if it writes.
  task automatic drive_entry(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                             input logic [2:0] f3, input logic [1:0] boff,
                             input logic [31:0] srcval, input logic [31:0] exp_val);
    exp_t e;
    in_src      = '0;
    in_src[sel*32 +: 32] = srcval;
    in_sel      = sel;
    in_rd       = rd;
    in_regwrite = rw;
    in_funct3   = f3;
    in_boff     = boff;
    in_valid    = 1'b1;
    if (rw && rd != 5'd0) begin
      e.rd = rd; e.data = exp_val;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a write is transferred when rf_we and rf_ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1 && rf_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
        chk("wr_data", rf_wdata, e.data);
        chk("fwd_copy", {fwd_valid, fwd_rd, fwd_data[25:0]}, {1'b1, e.rd, e.data[25:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0;
    rst_n = 1'b0; in_valid = 0; in_src = '0; in_sel = 0; in_rd = 0; in_regwrite = 0;
    in_funct3 = 0; in_boff = 0; flush = 0; rf_ready = 1'b1;
    in_valid3 = 0; in_src3 = '0; in_sel3 = 0;
    #2;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_retired", retired, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Basic ALU write.
    drive_entry(2'd0, 5'd5, 1'b1, 3'b010, 2'd0, 32'h0000_1234, 32'h0000_1234);
    chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t1_retired_before", retired, 32'd0);
    @(posedge clk); #1;
    chk("t1_retired_after", retired, 32'd1);

    // Stall with rd=7 for three cycles, then complete with a back-to-back accept.
    rf_ready = 1'b0;
    drive_entry(2'd3, 5'd7, 1'b1, 3'b010, 2'd0, 32'hCAFE_0007, 32'hCAFE_0007);
    r0 = retired;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_hold", {rf_we, rf_waddr, rf_wdata[25:0]}, {1'b1, 5'd7, 26'h2FE_0007});
      @(posedge clk); #1;
    end
    chk("stall_retired_hold", retired, r0);
    rf_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
    drive_entry(2'd2, 5'd9, 1'b1, 3'b010, 2'd0, 32'h0000_1004, 32'h0000_1004);
    chk("b2b_retired", retired, r0 + 32'd1);
    chk("b2b_waddr", {27'd0, rf_waddr}, 32'd9);
    @(posedge clk); #1;
    chk("b2b_retired2", retired, r0 + 32'd2);
    chk("b2b_empty_we", {31'd0, rf_we}, 32'd0);

    // rd=0 occupies one cycle with no write.
    r0 = retired;
    drive_entry(2'd0, 5'd0, 1'b1, 3'b010, 2'd0, 32'h5555_AAAA, 32'h0);
    chk("rd0_no_we", {31'd0, rf_we}, 32'd0);
    chk("rd0_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rd0_retired", retired, r0 + 32'd1);

    // Memory source, with or without load extension.
`ifdef WB_LOAD_EXT_EN
    drive_entry(2'd1, 5'd10, 1'b1, 3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
    drive_entry(2'd1, 5'd11, 1'b1, 3'b100, 2'd2, 32'h80FF_7F01, 32'h0000_00FF);
    drive_entry(2'd1, 5'd12, 1'b1, 3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
`else
    drive_entry(2'd1, 5'd10, 1'b1, 3'b000, 2'd3, 32'h80FF_7F01, 32'h80FF_7F01);
    drive_entry(2'd1, 5'd11, 1'b1, 3'b100, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
    drive_entry(2'd1, 5'd12, 1'b1, 3'b001, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
`endif
    @(posedge clk); #1;

    // Flush while stalled, with a new entry offered in the same cycle.
    rf_ready = 1'b0;
    drive_entry(2'd0, 5'd13, 1'b1, 3'b010, 2'd0, 32'h0000_0013, 32'h0000_0013);
    r0 = retired;
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd14; in_regwrite = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_we", {31'd0, rf_we}, 32'd0);
    chk("flush_retired", retired, r0);
    chk("flush_empty_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_hold_waddr", {27'd0, rf_waddr}, 32'd13);
    @(posedge clk); #1;
    chk("flush_nothing_accepted", {31'd0, rf_we}, 32'd0);

    // Asynchronous reset in the middle of a stall.
    drive_entry(2'd0, 5'd15, 1'b1, 3'b010, 2'd0, 32'h0000_0015, 32'h0000_0015);
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("async_rst_we", {31'd0, rf_we}, 32'd0);
    chk("async_rst_retired", retired, 32'd0);
    chk("async_rst_wdata", rf_wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rf_ready = 1'b1;
    chk("ready_after_rst2", {31'd0, in_ready}, 32'd1);

    // Out-of-range select yields zero; an in-range select still works.
    in_src3 = {32'h0000_ABCD, 32'h0000_2222, 32'h0000_1111};
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    @(posedge clk); #1;
    chk("sel_oob_zero", rf_wdata3, 32'd0);
    in_sel3 = 2'd2;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    chk("sel2_data", rf_wdata3, 32'h0000_ABCD);

    @(posedge clk); #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
